// File: rtl/pipeline_stage_register_if.sv
// Valid/ready channel for pipeline_stage_register: upstream D/in_valid/in_ready
// and downstream out_valid/out_ready. Q stays a plain port because it can be tri-stated.
interface pipeline_stage_register_if #(
   parameter int unsigned NrOfBits = 32
);
   logic [NrOfBits-1:0] D;
   logic                in_valid;
   logic                in_ready;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output D, in_valid, out_ready,
      input  in_ready, out_valid
   );

   modport slave (
      input  D, in_valid, out_ready,
      output in_ready, out_valid
   );
endinterface

// File: rtl/pipeline_stage_register.sv
// Two-entry skid buffer between pipeline stages, with flush, preset and a tri-stateable Q.
// Defining PIPE_REG_STALL_COUNT_EN adds a saturating StallCount output.
module pipeline_stage_register #(
   parameter int unsigned          NrOfBits    = 32,
   parameter logic [NrOfBits-1:0]  PresetValue = '0,
   parameter int unsigned          CountBits   = 16
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      ClockEnable,
   input  logic                      Tick,
   input  logic                      flush,
   input  logic                      pre,
   input  logic                      cs,
   pipeline_stage_register_if.slave  bus,
   output logic [NrOfBits-1:0]       Q
`ifdef PIPE_REG_STALL_COUNT_EN
   ,
   output logic [CountBits-1:0]      StallCount
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t              state_p1;
   state_t              state_nxt;
   logic [NrOfBits-1:0] main_p1;
   logic [NrOfBits-1:0] skid_p1;
   logic                en;
   logic                in_fire;
   logic                out_fire;
   logic                ld_main_d;
   logic                ld_main_skid;
   logic                ld_main_pre;
   logic                ld_skid;

   assign en       = ClockEnable & Tick;
   assign in_fire  = bus.in_valid & bus.in_ready & en;
   assign out_fire = bus.out_valid & bus.out_ready & en;

   // ---- stage p1: occupancy state ----
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state_p1 <= EMPTY;
      else        state_p1 <= state_nxt;
   end

   // flush outranks pre, which outranks the handshake; both drop any in_fire
   always_comb begin
      state_nxt    = state_p1;
      ld_main_d    = 1'b0;
      ld_main_skid = 1'b0;
      ld_main_pre  = 1'b0;
      ld_skid      = 1'b0;
      if (en) begin
         if (flush) begin
            state_nxt = EMPTY;
         end else if (pre) begin
            state_nxt   = ONE;
            ld_main_pre = 1'b1;
         end else begin
            case (state_p1)
               EMPTY: begin
                  if (in_fire) begin
                     ld_main_d = 1'b1;
                     state_nxt = ONE;
                  end
               end
               ONE: begin
                  if (in_fire && out_fire) begin
                     ld_main_d = 1'b1;
                  end else if (in_fire) begin
                     ld_skid   = 1'b1;
                     state_nxt = TWO;
                  end else if (out_fire) begin
                     state_nxt = EMPTY;
                  end
               end
               TWO: begin
                  if (out_fire) begin
                     ld_main_skid = 1'b1;
                     state_nxt    = ONE;
                  end
               end
               default: state_nxt = EMPTY;
            endcase
         end
      end
   end

   // Handshake outputs come from registered state only, so out_ready never reaches in_ready
   always_comb begin
      bus.in_ready  = 1'b1;
      bus.out_valid = 1'b0;
      case (state_p1)
         ONE: bus.out_valid = 1'b1;
         TWO: begin
            bus.out_valid = 1'b1;
            bus.in_ready  = 1'b0;
         end
         default: ;
      endcase
   end

   // ---- stage p1: main and skid data ----
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         main_p1 <= '0;
         skid_p1 <= '0;
      end else begin
         if (ld_main_pre)       main_p1 <= PresetValue;
         else if (ld_main_d)    main_p1 <= bus.D;
         else if (ld_main_skid) main_p1 <= skid_p1;
         if (ld_skid)           skid_p1 <= bus.D;
      end
   end

   assign Q = cs ? {NrOfBits{1'bz}} : main_p1;

`ifdef PIPE_REG_STALL_COUNT_EN
   function automatic logic [CountBits-1:0] sat_inc(input logic [CountBits-1:0] v);
      return (&v) ? v : v + CountBits'(1);
   endfunction

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         StallCount <= '0;
      end else if (en) begin
         if (flush)                                 StallCount <= '0;
         else if (bus.out_valid && !bus.out_ready)  StallCount <= sat_inc(StallCount);
      end
   end
`else
   localparam int unsigned unused_count_bits = CountBits;
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Directed plus randomized bench for pipeline_stage_register against a depth-2 queue model.
// Covers the stall counter too when PIPE_REG_STALL_COUNT_EN is defined.
module tb_pipeline_stage_register;
   localparam int unsigned     W      = 32;
   localparam logic [W-1:0]    PRESET = 32'h0000DEAD;
   localparam int unsigned     CB     = 16;

   logic   Clock = 1'b0;
   logic   Reset;
   logic   ClockEnable;
   logic   Tick;
   logic   flush;
   logic   pre;
   logic   cs;
   wire [W-1:0] Q;
`ifdef PIPE_REG_STALL_COUNT_EN
   wire [CB-1:0] StallCount;
`endif

   pipeline_stage_register_if #(.NrOfBits(W)) bus ();

   pipeline_stage_register #(
      .NrOfBits    (W),
      .PresetValue (PRESET),
      .CountBits   (CB)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .ClockEnable (ClockEnable),
      .Tick        (Tick),
      .flush       (flush),
      .pre         (pre),
      .cs          (cs),
      .bus         (bus),
      .Q           (Q)
`ifdef PIPE_REG_STALL_COUNT_EN
      ,
      .StallCount  (StallCount)
`endif
   );

   always #5 Clock = ~Clock;

   int           compared   = 0;
   int           mismatched = 0;
   logic [W-1:0] mq[$];
   logic [W-1:0] m_main = '0;
   int           m_stall = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".in_ready"},  W'(bus.in_ready),  W'(mq.size() < 2));
      check({tag, ".out_valid"}, W'(bus.out_valid), W'(mq.size() > 0));
      if (cs) begin
         compared++;
         // a two-state simulator resolves an undriven bus to zero
         assert ((Q === {W{1'bz}}) || (Q === '0)) else begin
            mismatched++;
            $error("FAIL %s.Q_released: observed %h expected all-z", tag, Q);
         end
      end else begin
         check({tag, ".Q"}, Q, m_main);
      end
`ifdef PIPE_REG_STALL_COUNT_EN
      check({tag, ".stall"}, W'(StallCount), W'(m_stall));
`endif
   endtask

   // Advance the model by one edge using the inputs about to be sampled, then compare.
   task automatic cycle(input string tag);
      logic en, inr, ov, inf, of;
      en  = ClockEnable & Tick;
      inr = (mq.size() < 2);
      ov  = (mq.size() > 0);
      inf = en & bus.in_valid & inr;
      of  = en & ov & bus.out_ready;
      if (en) begin
         if (flush)                    m_stall = 0;
         else if (ov && !bus.out_ready && m_stall < (1 << CB) - 1) m_stall++;
         if (flush) begin
            mq.delete();
         end else if (pre) begin
            mq.delete();
            mq.push_back(PRESET);
         end else begin
            if (of)  void'(mq.pop_front());
            if (inf) mq.push_back(bus.D);
         end
      end
      if (mq.size() > 0) m_main = mq[0];
      @(posedge Clock);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [W-1:0] stream_words [3];
      stream_words = '{32'h11, 32'h22, 32'h33};

      Reset = 1'b0; ClockEnable = 1'b1; Tick = 1'b1;
      flush = 1'b0; pre = 1'b0; cs = 1'b0;
      bus.D = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      check_all("reset");
      Reset = 1'b1;
      cycle("idle");

      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.D        = stream_words[i];
         cycle("stream");
      end
      bus.in_valid = 1'b0;
      cycle("drain");

      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.D = 32'hA1; cycle("stall_a1");
      bus.D = 32'hA2; cycle("stall_a2");
      bus.D = 32'hA3; cycle("stall_a3_blocked");
      bus.out_ready = 1'b1;
      cycle("release_a1");
      cycle("accept_a3");
      bus.in_valid = 1'b0;
      cycle("empty_a3");

      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.D = 32'hB1; cycle("fill_b1");
      bus.D = 32'hB2; cycle("fill_b2");
      flush = 1'b1; pre = 1'b1; bus.D = 32'hB3;
      cycle("flush_pre");
      flush = 1'b0;
      cycle("pre_only");
      pre = 1'b0; bus.in_valid = 1'b0;

      Tick = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1; flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.D = $urandom;
         cycle("tick_low");
      end
      Tick = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

      cs = 1'b1;
      cycle("cs_hold");
      bus.out_ready = 1'b1;
      cycle("cs_handshake");
      cs = 1'b0; bus.out_ready = 1'b0;
      cycle("cs_off");

      bus.in_valid = 1'b1; bus.D = 32'hC1;
      cycle("stall_load");
      bus.in_valid = 1'b0;
      for (int i = 0; i < 7; i++) cycle("stall_count");
      flush = 1'b1;
      cycle("stall_flush");
      flush = 1'b0;

      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      bus.D = 32'hE1; cycle("mid_e1");
      bus.D = 32'hE2; cycle("mid_e2");
      #3;
      Reset = 1'b0;
      #1;
      mq.delete(); m_main = '0; m_stall = 0;
      check_all("async_reset");
      bus.in_valid = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      cycle("after_reset");

      for (int i = 0; i < 400; i++) begin
         ClockEnable   = ($urandom_range(0, 7) != 0);
         Tick          = ($urandom_range(0, 7) != 0);
         flush         = ($urandom_range(0, 24) == 0);
         pre           = ($urandom_range(0, 24) == 0);
         cs            = ($urandom_range(0, 9) == 0);
         bus.in_valid  = $urandom_range(0, 1);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.D         = $urandom;
         cycle("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
